// File: rtl/crypto_sha256_msg_sched.sv
// rtl/crypto_sha256_msg_sched.sv - SHA-256 message schedule engine (optional block counter: CRYPTO_SHA2_SCHED_CNT_EN)
module crypto_sha256_msg_sched (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [5:0]  out_idx_o,
    output logic        busy_o,
    output logic [15:0] blocks_o
);

    typedef enum logic {ST_LOAD, ST_EXPAND} state_e;

    state_e      state_q, state_d;
    logic [6:0]  t_q, t_d;
    logic [31:0] sched_buf [16];
    logic        ld;
    logic        load_fire;
    logic        exp_fire;
    logic [3:0]  slot;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Handshake qualifiers and the next schedule word from the 16-entry window
    always_comb begin
        ld         = !out_valid_o || out_ready_i;
        in_ready_o = (state_q == ST_LOAD) && ld && !flush_i;
        load_fire  = in_valid_i && in_ready_o;
        exp_fire   = (state_q == ST_EXPAND) && ld && !flush_i;
        slot       = t_q[3:0];
        // slot indexes W[t-16]; 4-bit wraparound gives the (t-k)&15 positions
        w_new      = sig1(sched_buf[slot - 4'd2]) + sched_buf[slot - 4'd7]
                   + sig0(sched_buf[slot - 4'd15]) + sched_buf[slot];
        busy_o     = (t_q != 7'd0) || (state_q == ST_EXPAND);
    end

    // Next-state and round counter
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        if (flush_i) begin
            state_d = ST_LOAD;
            t_d     = 7'd0;
        end else if (load_fire) begin
            t_d = t_q + 7'd1;
            if (t_q == 7'd15) begin
                state_d = ST_EXPAND;
            end
        end else if (exp_fire) begin
            if (t_q == 7'd63) begin
                t_d     = 7'd0;
                state_d = ST_LOAD;
            end else begin
                t_d = t_q + 7'd1;
            end
        end
    end

    // State and round counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_LOAD;
            t_q     <= 7'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Single-entry output register; holds while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= 32'd0;
            out_idx_o   <= 6'd0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (load_fire) begin
            out_valid_o <= 1'b1;
            out_data_o  <= in_data_i;
            out_idx_o   <= t_q[5:0];
        end else if (exp_fire) begin
            out_valid_o <= 1'b1;
            out_data_o  <= w_new;
            out_idx_o   <= t_q[5:0];
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Circular window: each new word replaces the one 16 rounds older
    always_ff @(posedge clk_i) begin
        if (load_fire) begin
            sched_buf[slot] <= in_data_i;
        end else if (exp_fire) begin
            sched_buf[slot] <= w_new;
        end
    end

`ifdef CRYPTO_SHA2_SCHED_CNT_EN
    logic [15:0] blocks_q;

    // Count blocks whose final word W[63] was taken by the consumer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blocks_q <= 16'd0;
        end else if (out_valid_o && out_ready_i && (out_idx_o == 6'd63)) begin
            blocks_q <= blocks_q + 16'd1;
        end
    end

    assign blocks_o = blocks_q;
`else
    assign blocks_o = 16'd0;
`endif

endmodule

// File: tb/tb_crypto_sha256_msg_sched.sv
// tb/tb_crypto_sha256_msg_sched.sv - directed self-checking bench for crypto_sha256_msg_sched
module tb_crypto_sha256_msg_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [5:0]  out_idx_o;
    logic        busy_o;
    logic [15:0] blocks_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] msg  [16];
    logic [31:0] wref [64];
    int          last_vcyc;
    int          last_gaps;

`ifdef CRYPTO_SHA2_SCHED_CNT_EN
    localparam logic [31:0] EXP_BLOCKS_B2B = 32'd2;
`else
    localparam logic [31:0] EXP_BLOCKS_B2B = 32'd0;
`endif

    crypto_sha256_msg_sched dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_idx_o   (out_idx_o),
        .busy_o      (busy_o),
        .blocks_o    (blocks_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive nb "abc" blocks and consume the schedule, checking every delivered word.
    // ready_pat[cyc % 5] sets out_ready_i; hold keeps in_valid_i high during expansion;
    // stop_at >= 0 returns once that many words have been consumed.
    task automatic stream(input int nb, input logic [4:0] ready_pat, input bit hold, input int stop_at);
        int          tcnt = 0;
        int          rcv = 0;
        int          cyc = 0;
        int          vcyc = 0;
        int          gaps = 0;
        bit          seen = 0;
        logic        prev_v = 1'b0;
        logic        prev_r = 1'b0;
        logic [31:0] prev_d = 32'd0;
        logic [5:0]  prev_i = 6'd0;
        while (rcv < 64 * nb && rcv != stop_at && cyc < 64 * nb * 6 + 50) begin
            @(negedge clk_i);
            out_ready_i = ready_pat[cyc % 5];
            in_valid_i  = (tcnt < 16 * nb) || (hold && rcv < 63);
            in_data_i   = (tcnt < 16 * nb) ? msg[tcnt % 16] : 32'hDEAD_BEEF;
            #1;
            if (prev_v && !prev_r) begin
                chk("stall_valid", {31'd0, out_valid_o}, 32'd1);
                chk("stall_data", out_data_o, prev_d);
                chk("stall_idx", {26'd0, out_idx_o}, {26'd0, prev_i});
            end
            if (out_valid_o) begin
                seen = 1;
                vcyc++;
            end else if (seen) begin
                gaps++;
            end
            if (out_valid_o && out_idx_o >= 6'd15 && out_idx_o < 6'd63)
                chk("in_ready_expand", {31'd0, in_ready_o}, 32'd0);
            if (out_valid_o && out_ready_i) begin
                chk("idx", {26'd0, out_idx_o}, rcv % 64);
                chk("word", out_data_o, wref[rcv % 64]);
                if (out_idx_o == 6'd16) chk("w16", out_data_o, 32'h6162_6380);
                if (out_idx_o == 6'd17) chk("w17", out_data_o, 32'h000F_0000);
                if (out_idx_o == 6'd63) chk("w63", out_data_o, 32'h12B1_EDEB);
                rcv++;
            end
            if (in_valid_i && in_ready_o) begin
                chk("accept_gate", {31'd0, tcnt < 16 * nb}, 32'd1);
                tcnt++;
            end
            prev_v = out_valid_o;
            prev_r = out_ready_i;
            prev_d = out_data_o;
            prev_i = out_idx_o;
            cyc++;
        end
        if (stop_at < 0) chk("words_received", rcv, 64 * nb);
        in_valid_i = 1'b0;
        last_vcyc  = vcyc;
        last_gaps  = gaps;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) msg[i] = 32'd0;
        msg[0]  = 32'h6162_6380;
        msg[15] = 32'h0000_0018;
        for (int i = 0; i < 16; i++) wref[i] = msg[i];
        for (int i = 16; i < 64; i++) begin
            wref[i] = (rotr(wref[i-2], 17) ^ rotr(wref[i-2], 19) ^ (wref[i-2] >> 10))
                    + wref[i-7]
                    + (rotr(wref[i-15], 7) ^ rotr(wref[i-15], 18) ^ (wref[i-15] >> 3))
                    + wref[i-16];
        end

        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 32'd0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_out_data", out_data_o, 32'd0);
        chk("rst_out_idx", {26'd0, out_idx_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_blocks", {16'd0, blocks_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

        stream(1, 5'b11111, 1'b0, -1);
        chk("abc_valid_cycles", last_vcyc, 32'd64);
        chk("abc_gaps", last_gaps, 32'd0);

        stream(1, 5'b01101, 1'b0, -1);

        stream(1, 5'b11111, 1'b0, 30);
        @(negedge clk_i);
        flush_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hFFFF_FFFF;
        out_ready_i = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready_o}, 32'd0);
        @(negedge clk_i);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        stream(1, 5'b11111, 1'b0, -1);

        stream(1, 5'b11111, 1'b0, 40);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("arst_out_data", out_data_o, 32'd0);
        chk("arst_out_idx", {26'd0, out_idx_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_blocks", {16'd0, blocks_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("arst_in_ready", {31'd0, in_ready_o}, 32'd1);

        stream(2, 5'b11111, 1'b0, -1);
        chk("b2b_valid_cycles", last_vcyc, 32'd128);
        chk("b2b_gaps", last_gaps, 32'd0);
        @(negedge clk_i);
        #1;
        chk("b2b_blocks", {16'd0, blocks_o}, EXP_BLOCKS_B2B);

        stream(1, 5'b11111, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crypto_sha256_msg_sched.md
# crypto_sha256_msg_sched

Sequential SHA-256 message-schedule engine for the ibex-crypto datapath. It accepts one 512-bit block as 16 big-endian 32-bit words and emits the 64 schedule words W[0..63] in order. W[16..63] are computed in hardware using the sigma0/sigma1 functions. It sits between the message-block loader and the compression round logic, and consumes the same small-sigma definitions the scalar SHA2 instructions produce.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort of current block; highest priority
- in_valid_i  in  1  message word valid
- in_ready_o  out  1  message word accepted when in_valid_i && in_ready_o
- in_data_i  in  32  message word M[t], t = 0..15
- out_valid_o  out  1  schedule word valid (registered)
- out_ready_i  in  1  consumer accepts when out_valid_o && out_ready_i
- out_data_o  out  32  schedule word W[t] (registered)
- out_idx_o  out  6  index t of out_data_o (registered)
- busy_o  out  1  block in progress (t != 0 or state EXPAND)
- blocks_o  out  16  completed-block count (see Configuration)

## Operation
- Storage: 16 x 32 circular buffer buf; round counter t[6:0]; single-entry output register {out_data_o, out_idx_o, out_valid_o}.
- Output register load enable: ld = !out_valid_o || out_ready_i.
- Functions: sig0(x) = ROTR7 ^ ROTR18 ^ SHR3; sig1(x) = ROTR17 ^ ROTR19 ^ SHR10. Sum is modulo 2^32; carries are dropped.
- LOAD state (t = 0..15):
  - in_ready_o = ld.
  - On accept: buf[t] <= in_data_i; output register <= {in_data_i, t, 1}; t++.
  - Accepting t = 15 moves the state to EXPAND.
- EXPAND state (t = 16..63):
  - in_ready_o = 0.
  - When ld: W = sig1(buf[(t-2)&15]) + buf[(t-7)&15] + sig0(buf[(t-15)&15]) + buf[t&15]. buf[t&15] (the old W[t-16]) is then overwritten with W.
  - Output register <= {W, t, 1}; t++.
  - Producing t = 63 sets t to 0 and moves the state to LOAD.
- A new block may begin only after W[63] is loaded. Its first word is accepted when ld holds.
- flush_i:
  - state <= LOAD, t <= 0, out_valid_o <= 0.
  - A word presented in the same cycle is not accepted (in_ready_o = 0 while flush_i is high).
  - buf contents are don't-care.
- Output register holds its value while out_valid_o && !out_ready_i. EXPAND stalls with no buffer writes during that time.

## Timing
- Reset values: state LOAD, t = 0, out_valid_o = 0, out_data_o = 0, out_idx_o = 0, busy_o = 0, blocks_o = 0. in_ready_o = 1 after reset while flush_i = 0.
- Latency: word accepted (or computed) in cycle N is visible on out_* in cycle N+1.
- Throughput: 1 word/cycle with out_ready_i held high. A full block takes 64 cycles after the first accept, with no bubble between W[15] and W[16].
- Back-to-back blocks: first word of the next block can be accepted in the cycle W[63] is loaded + 1. There is zero gap when out_ready_i = 1.
- in_ready_o is combinational from out_valid_o, out_ready_i, state and flush_i. There is no combinational path from in_valid_i to out_*.
- Reset mid-block: all state returns to reset values immediately. Partial block is discarded.

## Configuration
- CRYPTO_SHA2_SCHED_CNT_EN defined:
  - blocks_o increments by 1 on the handshake of out_idx_o = 63, wrapping at 2^16.
  - flush_i does not clear it; reset does.
- Not defined: blocks_o is tied to 0 and the counter is not synthesized. All other behaviour is identical.

## Test plan
- Block "abc": M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018, with out_ready_i = 1.
  - Expect idx 0..15 to echo the inputs.
  - Expect W16 = 0x61626380, W17 = 0x000F0000, W63 = 0x12B1EDEB.
  - Expect 64 consecutive valid cycles.
- Backpressure: repeat "abc" with out_ready_i toggling 1-0-1-1-0.
  - Words and indices are identical to the first run; none are dropped or duplicated.
  - out_data_o is stable while stalled.
- Back-to-back: two "abc" blocks streamed continuously.
  - Second block's idx 0 appears the cycle after the first block's idx 63.
  - With CRYPTO_SHA2_SCHED_CNT_EN, blocks_o = 2.
- Flush at t = 30: assert flush_i for one cycle.
  - out_valid_o = 0 next cycle and busy_o = 0.
  - A fresh "abc" block then produces W16 = 0x61626380.
- Async reset: assert rst_ni low mid-EXPAND, between clock edges.
  - All outputs reach reset values without a clock edge.
  - in_ready_o = 1 after release.
- Input gating: hold in_valid_i = 1 during EXPAND.
  - in_ready_o = 0 for idx 16..63.
  - No buffer corruption; W63 = 0x12B1EDEB.
